// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter: latches the winner's command, drives the
// shared burst interface, counts beats and returns read data / completion to the owner.
module bus_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              io_m0_req,
    input  logic              io_m0_wr,
    input  logic              io_m0_rd,
    input  logic [ADDR_W-1:0] io_m0_address,
    input  logic [LEN_W-1:0]  io_m0_length,
    input  logic [DATA_W-1:0] io_m0_wdata,
    output logic              io_m0_grant,
    output logic [DATA_W-1:0] io_m0_rdata,
    output logic              io_m0_rvalid,
    output logic              io_m0_done,

    input  logic              io_m1_req,
    input  logic              io_m1_wr,
    input  logic              io_m1_rd,
    input  logic [ADDR_W-1:0] io_m1_address,
    input  logic [LEN_W-1:0]  io_m1_length,
    input  logic [DATA_W-1:0] io_m1_wdata,
    output logic              io_m1_grant,
    output logic [DATA_W-1:0] io_m1_rdata,
    output logic              io_m1_rvalid,
    output logic              io_m1_done,

    output logic              io_bus_start,
    output logic              io_bus_wr,
    output logic              io_bus_rd,
    output logic [ADDR_W-1:0] io_bus_address,
    output logic [LEN_W-1:0]  io_bus_length,
    output logic [DATA_W-1:0] io_bus_wdata,
    input  logic [DATA_W-1:0] io_bus_rdata,
    input  logic              io_bus_beat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                wr_q;
    logic                rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic                start_q;
    logic                grant0_q;
    logic                grant1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic                done0_q;
    logic                done1_q;

    logic                win_d;
    logic                sel_wr_d;
    logic                sel_rd_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [LEN_W-1:0]    sel_len_d;
    logic [LEN_W-1:0]    len_eff_d;

    // On contention the requester that did not win last time is preferred.
    always_comb begin
        if (io_m0_req && io_m1_req) begin
            win_d = ~last_grant_q;
        end else begin
            win_d = io_m1_req;
        end
    end

    always_comb begin
        sel_wr_d   = win_d ? io_m1_wr      : io_m0_wr;
        sel_addr_d = win_d ? io_m1_address : io_m0_address;
        sel_len_d  = win_d ? io_m1_length  : io_m0_length;
        // Write wins over read; read is implied when neither is set.
        sel_rd_d   = win_d ? ((io_m1_rd & ~io_m1_wr) | (~io_m1_rd & ~io_m1_wr))
                           : ((io_m0_rd & ~io_m0_wr) | (~io_m0_rd & ~io_m0_wr));
        len_eff_d  = (sel_len_d == '0) ? LEN_W'(1) : sel_len_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            start_q      <= 1'b0;
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (io_m0_req || io_m1_req) begin
                        owner_q  <= win_d;
                        wr_q     <= sel_wr_d;
                        rd_q     <= sel_rd_d;
                        addr_q   <= sel_addr_d;
                        len_q    <= len_eff_d;
                        cnt_q    <= len_eff_d;
                        grant0_q <= ~win_d;
                        grant1_q <= win_d;
                        start_q  <= 1'b1;
                        state_q  <= BURST;
                    end
                end
                BURST: begin
                    if (io_bus_beat) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (rd_q) begin
                            if (owner_q) begin
                                rdata1_q  <= io_bus_rdata;
                                rvalid1_q <= 1'b1;
                            end else begin
                                rdata0_q  <= io_bus_rdata;
                                rvalid0_q <= 1'b1;
                            end
                        end
                        // Final beat: its data is still captured above.
                        if (cnt_q == LEN_W'(1)) begin
                            start_q <= 1'b0;
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    grant0_q     <= 1'b0;
                    grant1_q     <= 1'b0;
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_m0_grant    = grant0_q;
    assign io_m1_grant    = grant1_q;
    assign io_m0_rdata    = rdata0_q;
    assign io_m1_rdata    = rdata1_q;
    assign io_m0_rvalid   = rvalid0_q;
    assign io_m1_rvalid   = rvalid1_q;
    assign io_m0_done     = done0_q;
    assign io_m1_done     = done1_q;

    assign io_bus_start   = start_q;
    assign io_bus_wr      = wr_q;
    assign io_bus_rd      = rd_q;
    assign io_bus_address = addr_q;
    assign io_bus_length  = len_q;
    assign io_bus_wdata   = start_q ? (owner_q ? io_m1_wdata : io_m0_wdata) : '0;

    a_grant_onehot : assert property (@(posedge clock) disable iff (reset)
        !(grant0_q && grant1_q));

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester round-robin arbiter placed in front of the master/slave transfer FSM pair. It shares the single bus between requesters 0 and 1. It latches the winner's command (wr/rd, address, length), drives the bus start/command lines for the whole burst and counts beats. It returns read data and a completion pulse to the granted requester.

## Interface
- DATA_W, 32, width of wdata/rdata
- ADDR_W, 4, width of address
- LEN_W, 4, width of burst length

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- io_m0_req / io_m1_req  in  1  request; hold high until done
- io_mN_wr, io_mN_rd  in  1  command; wr wins if both set, rd implied if neither
- io_mN_address  in  ADDR_W  start address
- io_mN_length  in  LEN_W  beats; 0 treated as 1
- io_mN_wdata  in  DATA_W  write data for the current beat (live, not latched)
- io_mN_grant  out  1  requester owns the bus
- io_mN_rdata  out  DATA_W  last read beat, registered
- io_mN_rvalid  out  1  one-cycle pulse per read beat
- io_mN_done  out  1  one-cycle pulse after the last beat
- io_bus_start  out  1  burst active towards the master FSM
- io_bus_wr, io_bus_rd  out  1  latched command
- io_bus_address  out  ADDR_W  latched address
- io_bus_length  out  LEN_W  latched length (0 forwarded as 1)
- io_bus_wdata  out  DATA_W  granted requester's io_mN_wdata
- io_bus_rdata  in  DATA_W  read data, valid with beat
- io_bus_beat  in  1  one beat completed this cycle

## Operation
- States: IDLE, BURST, DONE.
- last_grant register resets to 1, so m0 wins the first contention.
- IDLE transitions:
  - No req: stay in IDLE.
  - Single req: that requester wins.
  - Both req: the requester other than last_grant wins.
  - On a win: latch command, load beat counter with max(length,1), set owner and grant, go BURST.
- BURST outputs:
  - io_bus_start=1.
  - Command/address/length come from latches.
  - io_bus_wdata is muxed from the owner.
  - Non-owner sees grant=0, rvalid=0, done=0.
- Beat handling: each io_bus_beat decrements the counter.
  - Read bursts only: io_bus_rdata is registered into owner rdata and owner rvalid pulses the next cycle.
  - Beat with counter==1: go DONE.
- DONE:
  - io_bus_start=0, grant stays high this cycle, owner done=1.
  - last_grant<=owner; go IDLE, grant drops.
- Requester must deassert req in the cycle after done. If req is still high it is a new request and re-enters arbitration at round-robin priority.
- req dropping during BURST is ignored; the burst runs to completion.
- io_bus_beat outside BURST is ignored.
- Beat counter is LEN_W bits; a length of 15 produces 15 beats, no wrap.

## Timing
- Reset (async, immediate): state=IDLE, all outputs 0, counter 0, latches 0, last_grant=1. Reset mid-burst abandons the burst with no done pulse.
- Arbitration latency: req sampled high at edge k gives grant and io_bus_start high after edge k (visible in cycle k+1).
- Beat at edge j: rvalid/rdata visible after edge j. The last beat at edge j gives done after edge j, and IDLE after edge j+1.
- Minimum occupancy for a 1-beat burst is 3 cycles (arb, BURST with beat, DONE). Back-to-back grants are separated by at least one IDLE cycle.
- Simultaneous beat and the final count: the DONE transition takes precedence; the beat is still counted and data still captured.

## Test plan
- Reset, m0 req write, addr 7, len 1, wdata 0xA, beat after 2 cycles -> bus_start=1/wr=1/address=7/wdata=0xA; m0_done one pulse; grant drops; m1 untouched.
- m1 read, addr 7, len 3, beats returning 0x11, 0x22, 0x33 -> three m1_rvalid pulses with those rdata values; done after the third beat; m1_rdata holds 0x33.
- Both req held continuously, len 1 each -> grants go m0, m1, m0, m1; no cycle where both grants are high.
- Length 0 with rd=1 and wr=1 -> bus_length=1, bus_wr=1, bus_rd=0, single beat, done.
- Assert reset mid-burst (after 1 of 4 beats) -> all outputs 0 immediately, no done. After release m0 wins contention first.
- Extra io_bus_beat in IDLE, and m0 drops req mid-burst -> no state change in IDLE; the burst still completes with done.
